// File: rtl/cpu_status_flags.sv
// ---------------------------------------------------------------------------
// cpu_status_flags
//   Processor status (P) register plus interrupt sampler, sitting directly
//   downstream of the 8-bit ALU.  Merges the ALU's registered flag outputs
//   with explicit flag commands and stack loads (PLP/RTI), feeds carry and
//   BCD mode back to the ALU, qualifies IRQ against I and edge-detects NMI.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   RDY                   global stall; low freezes flags and pending update
//   alu_CO/V/Z/N          ALU flags, valid the cycle after the ALU op
//   flag_upd, upd_mask    request ALU flag writeback, mask {N,V,Z,C}
//   flag_cmd_en, flag_cmd explicit CLC/SEC/CLI/SEI/CLD/SED/CLV (7 = no-op)
//   plp, DI               load P from the data bus
//   set_i                 interrupt entry, forces I=1
//   brk                   B bit value used in P_push
//   IRQ_n, NMI_n          interrupt inputs, active low (IRQ level, NMI edge)
//   nmi_ack, irq_ack      sequencer accepted the interrupt
//   P, P_push             status register / pushed image
//   C_out, D_out          carry-in and decimal mode to the ALU
//   irq_pending, nmi_pending
// ---------------------------------------------------------------------------
module cpu_status_flags #(
    parameter logic P_UNUSED_BIT = 1'b1,
    parameter int   I_MASK_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RDY,
    input  logic       alu_CO,
    input  logic       alu_V,
    input  logic       alu_Z,
    input  logic       alu_N,
    input  logic       flag_upd,
    input  logic [3:0] upd_mask,
    input  logic       flag_cmd_en,
    input  logic [2:0] flag_cmd,
    input  logic       plp,
    input  logic [7:0] DI,
    input  logic       set_i,
    input  logic       brk,
    input  logic       IRQ_n,
    input  logic       NMI_n,
    input  logic       nmi_ack,
    input  logic       irq_ack,
    output logic [7:0] P,
    output logic [7:0] P_push,
    output logic       C_out,
    output logic       D_out,
    output logic       irq_pending,
    output logic       nmi_pending
);

    typedef enum logic [2:0] {
        CMD_CLC = 3'd0,
        CMD_SEC = 3'd1,
        CMD_CLI = 3'd2,
        CMD_SEI = 3'd3,
        CMD_CLD = 3'd4,
        CMD_SED = 3'd5,
        CMD_CLV = 3'd6,
        CMD_NOP = 3'd7
    } flag_cmd_e;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_RST = '{n: 1'b0, v: 1'b0, d: 1'b0,
                                     i: 1'b1, z: 1'b0, c: 1'b0};

    flags_t     flags, flags_nx;
    logic       pend_valid;
    logic [3:0] pend_mask;      // {N,V,Z,C}
    logic       i_delayed;
    logic       nmi_q;          // previous NMI_n sample
    logic       nmi_fall;
    logic       i_eff;
    flag_cmd_e  cmd;

    // DI[5:4] have no home in P; irq_ack has no effect beyond set_i.
    logic       in_unused;
    assign in_unused = ^{DI[5:4], irq_ack};

    assign cmd = flag_cmd_e'(flag_cmd);

    // Next flag values for an RDY edge. Sources are applied lowest
    // priority first so that later assignments override per bit:
    // pending ALU update < flag_cmd < set_i < plp.
    always_comb begin
        flags_nx = flags;

        if (pend_valid) begin
            if (pend_mask[0]) flags_nx.c = alu_CO;
            if (pend_mask[1]) flags_nx.z = alu_Z;
            if (pend_mask[2]) flags_nx.v = alu_V;
            if (pend_mask[3]) flags_nx.n = alu_N;
        end

        if (flag_cmd_en) begin
            case (cmd)
                CMD_CLC: flags_nx.c = 1'b0;
                CMD_SEC: flags_nx.c = 1'b1;
                CMD_CLI: flags_nx.i = 1'b0;
                CMD_SEI: flags_nx.i = 1'b1;
                CMD_CLD: flags_nx.d = 1'b0;
                CMD_SED: flags_nx.d = 1'b1;
                CMD_CLV: flags_nx.v = 1'b0;
                default: ;
            endcase
        end

        if (set_i) flags_nx.i = 1'b1;

        if (plp) begin
            flags_nx.n = DI[7];
            flags_nx.v = DI[6];
            flags_nx.d = DI[3];
            flags_nx.i = DI[2];
            flags_nx.z = DI[1];
            flags_nx.c = DI[0];
        end
    end

    // Flag state and ALU writeback pipeline, both frozen while RDY is low.
    // A pending update is consumed on the next RDY edge (the ALU result is
    // valid then); a new flag_upd on that edge re-arms it. When plp wins the
    // edge the old pending update is simply not applied, which discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= FLAGS_RST;
            pend_valid <= 1'b0;
            pend_mask  <= 4'b0000;
            i_delayed  <= 1'b1;
        end else if (RDY) begin
            flags      <= flags_nx;
            pend_valid <= flag_upd;
            if (flag_upd) pend_mask <= upd_mask;
            i_delayed  <= flags.i;
        end
    end

    // NMI sampling runs every clock so an edge during a stall is not lost.
    assign nmi_fall = nmi_q & ~NMI_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_q       <= 1'b1;
            nmi_pending <= 1'b0;
        end else begin
            nmi_q <= NMI_n;
            // A fresh edge beats a coincident acknowledge.
            if (nmi_fall)
                nmi_pending <= 1'b1;
            else if (nmi_ack && RDY)
                nmi_pending <= 1'b0;
        end
    end

    // With the delay enabled, CLI followed by an asserted IRQ stays masked for
    // one more RDY cycle, giving the one-instruction window of the original.
    generate
        if (I_MASK_DELAY == 0) begin : g_i_direct
            assign i_eff = flags.i;
        end else begin : g_i_delayed
            assign i_eff = i_delayed;
        end
    endgenerate

    assign irq_pending = ~IRQ_n & ~i_eff;

    assign P      = {flags.n, flags.v, P_UNUSED_BIT, 1'b0,
                     flags.d, flags.i, flags.z, flags.c};
    assign P_push = {flags.n, flags.v, 1'b1, brk,
                     flags.d, flags.i, flags.z, flags.c};
    assign C_out  = flags.c;
    assign D_out  = flags.d;

endmodule

// File: tb/tb_cpu_status_flags.sv
// ---------------------------------------------------------------------------
// tb_cpu_status_flags
//   Directed bench for cpu_status_flags: reset, ALU writeback with stalls,
//   source priority, IRQ mask delay, NMI edge capture, P_push and async reset.
// ---------------------------------------------------------------------------
module tb_cpu_status_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RDY;
    logic       alu_CO, alu_V, alu_Z, alu_N;
    logic       flag_upd;
    logic [3:0] upd_mask;
    logic       flag_cmd_en;
    logic [2:0] flag_cmd;
    logic       plp;
    logic [7:0] DI;
    logic       set_i, brk;
    logic       IRQ_n, NMI_n;
    logic       nmi_ack, irq_ack;
    logic [7:0] P, P_push;
    logic       C_out, D_out, irq_pending, nmi_pending;

    int tests = 0;
    int fails = 0;

    cpu_status_flags dut (
        .clk(clk), .rst_n(rst_n), .RDY(RDY),
        .alu_CO(alu_CO), .alu_V(alu_V), .alu_Z(alu_Z), .alu_N(alu_N),
        .flag_upd(flag_upd), .upd_mask(upd_mask),
        .flag_cmd_en(flag_cmd_en), .flag_cmd(flag_cmd),
        .plp(plp), .DI(DI), .set_i(set_i), .brk(brk),
        .IRQ_n(IRQ_n), .NMI_n(NMI_n), .nmi_ack(nmi_ack), .irq_ack(irq_ack),
        .P(P), .P_push(P_push), .C_out(C_out), .D_out(D_out),
        .irq_pending(irq_pending), .nmi_pending(nmi_pending)
    );

    always #5 clk = ~clk;

    // One clock, then settle 1ns past the edge before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RDY = 1'b1;
        alu_CO = 0; alu_V = 0; alu_Z = 0; alu_N = 0;
        flag_upd = 0; upd_mask = 4'h0; flag_cmd_en = 0; flag_cmd = 3'd0;
        plp = 0; DI = 8'h00; set_i = 0; brk = 0;
        IRQ_n = 1'b0; NMI_n = 1'b1; nmi_ack = 0; irq_ack = 0;
        step(); step();
        tests++; if (P !== 8'h24) begin fails++; $display("FAIL reset_P got %h exp 24", P); end
        tests++; if (C_out !== 1'b0) begin fails++; $display("FAIL reset_C_out got %b exp 0", C_out); end
        tests++; if (D_out !== 1'b0) begin fails++; $display("FAIL reset_D_out got %b exp 0", D_out); end
        tests++; if (irq_pending !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq_pending); end
        tests++; if (nmi_pending !== 1'b0) begin fails++; $display("FAIL reset_nmi got %b exp 0", nmi_pending); end
        rst_n = 1'b1; IRQ_n = 1'b1;
        step();
    endtask

    task automatic test_alu_update();
        flag_upd = 1; upd_mask = 4'b1111;
        step();                                   // edge k
        flag_upd = 0;
        alu_N = 1; alu_V = 0; alu_Z = 0; alu_CO = 1;
        tests++; if (P !== 8'h24) begin fails++; $display("FAIL alu_latency got %h exp 24", P); end
        step();                                   // edge k+1
        tests++; if (P !== 8'hA5) begin fails++; $display("FAIL alu_load got %h exp A5", P); end
        tests++; if (C_out !== 1'b1) begin fails++; $display("FAIL alu_C_out got %b exp 1", C_out); end
        // Same again with a three-cycle stall before the consuming edge.
        flag_upd = 1;
        step();
        flag_upd = 0; RDY = 0;
        alu_N = 0; alu_V = 1; alu_Z = 1; alu_CO = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (P !== 8'hA5) begin fails++; $display("FAIL alu_stall%0d got %h exp A5", k, P); end
        end
        RDY = 1;
        step();
        tests++; if (P !== 8'h66) begin fails++; $display("FAIL alu_after_stall got %h exp 66", P); end
    endtask

    task automatic test_priority();
        // Pending Z,C update with SEC in the same edge: C from command, Z from ALU.
        flag_upd = 1; upd_mask = 4'b0011;
        step();
        flag_upd = 0; flag_cmd_en = 1; flag_cmd = 3'd1;
        alu_CO = 0; alu_Z = 0;
        step();
        tests++; if (P !== 8'h65) begin fails++; $display("FAIL prio_sec_vs_alu got %h exp 65", P); end
        // Pending full update, CLC and plp together: plp wins everything.
        flag_cmd_en = 0;
        flag_upd = 1; upd_mask = 4'b1111;
        step();
        flag_upd = 0; plp = 1; DI = 8'hC3;
        flag_cmd_en = 1; flag_cmd = 3'd0;
        alu_N = 0; alu_V = 0; alu_Z = 0; alu_CO = 0;
        step();
        tests++; if (P !== 8'hE3) begin fails++; $display("FAIL prio_plp got %h exp E3", P); end
        plp = 0; flag_cmd_en = 0;
        step();
        tests++; if (P !== 8'hE3) begin fails++; $display("FAIL plp_discard got %h exp E3", P); end
        // Reserved command
        flag_cmd_en = 1; flag_cmd = 3'd7;
        step();
        tests++; if (P !== 8'hE3) begin fails++; $display("FAIL cmd_reserved got %h exp E3", P); end
        flag_cmd = 3'd5;                          // SED
        step();
        tests++; if (P !== 8'hEB || D_out !== 1'b1) begin fails++; $display("FAIL cmd_sed got %h/%b exp EB/1", P, D_out); end
        flag_cmd = 3'd4;                          // CLD
        step();
        tests++; if (P !== 8'hE3) begin fails++; $display("FAIL cmd_cld got %h exp E3", P); end
        flag_cmd = 3'd6;                          // CLV
        step();
        tests++; if (P !== 8'hA3) begin fails++; $display("FAIL cmd_clv got %h exp A3", P); end
        flag_cmd = 3'd2; set_i = 1;               // CLI vs set_i
        step();
        tests++; if (P !== 8'hA7) begin fails++; $display("FAIL seti_vs_cli got %h exp A7", P); end
        set_i = 0; flag_cmd_en = 0;
        step();
    endtask

    task automatic test_irq();
        IRQ_n = 0;
        #1;
        tests++; if (irq_pending !== 1'b0) begin fails++; $display("FAIL irq_masked got %b exp 0", irq_pending); end
        flag_cmd_en = 1; flag_cmd = 3'd2;         // CLI
        step();
        flag_cmd_en = 0;
        tests++; if (irq_pending !== 1'b0) begin fails++; $display("FAIL irq_cli_delay got %b exp 0", irq_pending); end
        step();
        tests++; if (irq_pending !== 1'b1) begin fails++; $display("FAIL irq_cli_open got %b exp 1", irq_pending); end
        flag_cmd_en = 1; flag_cmd = 3'd3;         // SEI
        step();
        flag_cmd_en = 0;
        tests++; if (irq_pending !== 1'b1) begin fails++; $display("FAIL irq_sei_delay got %b exp 1", irq_pending); end
        step();
        tests++; if (irq_pending !== 1'b0) begin fails++; $display("FAIL irq_sei_mask got %b exp 0", irq_pending); end
        IRQ_n = 1;
    endtask

    task automatic test_nmi();
        RDY = 0; NMI_n = 0;
        step();
        tests++; if (nmi_pending !== 1'b1) begin fails++; $display("FAIL nmi_edge_stall got %b exp 1", nmi_pending); end
        nmi_ack = 1;                              // ack ignored without RDY
        step(); step();
        tests++; if (nmi_pending !== 1'b1) begin fails++; $display("FAIL nmi_held got %b exp 1", nmi_pending); end
        RDY = 1;
        step();
        nmi_ack = 0;
        tests++; if (nmi_pending !== 1'b0) begin fails++; $display("FAIL nmi_ack got %b exp 0", nmi_pending); end
        step(); step(); step();
        tests++; if (nmi_pending !== 1'b0) begin fails++; $display("FAIL nmi_no_retrigger got %b exp 0", nmi_pending); end
        NMI_n = 1;
        step();
        NMI_n = 0;
        step();
        NMI_n = 1;
        step();
        NMI_n = 0; nmi_ack = 1;                   // new edge coincident with ack
        step();
        nmi_ack = 0;
        tests++; if (nmi_pending !== 1'b1) begin fails++; $display("FAIL nmi_edge_vs_ack got %b exp 1", nmi_pending); end
    endtask

    task automatic test_brk_reset();
        brk = 1;
        #1;
        tests++; if (P_push !== 8'hB7) begin fails++; $display("FAIL push_brk got %h exp B7", P_push); end
        brk = 0;
        #1;
        tests++; if (P_push !== 8'hA7 || P[4] !== 1'b0) begin fails++; $display("FAIL push_nobrk got %h exp A7", P_push); end
        // Arm a full update, then reset mid-cycle before it is consumed.
        flag_upd = 1; upd_mask = 4'b1111;
        step();
        flag_upd = 0;
        alu_N = 1; alu_V = 1; alu_Z = 1; alu_CO = 1;
        #1 rst_n = 0;
        #1;
        tests++; if (P !== 8'h24) begin fails++; $display("FAIL async_reset_P got %h exp 24", P); end
        tests++; if (nmi_pending !== 1'b0) begin fails++; $display("FAIL async_reset_nmi got %b exp 0", nmi_pending); end
        rst_n = 1;
        step();
        tests++; if (P !== 8'h24) begin fails++; $display("FAIL reset_discard got %h exp 24", P); end
        brk = 1;
        #1;
        tests++; if (P_push !== 8'h34) begin fails++; $display("FAIL push_reset_brk got %h exp 34", P_push); end
        brk = 0;
    endtask

    initial begin
        test_reset();
        test_alu_update();
        test_priority();
        test_irq();
        test_nmi();
        test_brk_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_status_flags.md
Name: cpu_status_flags

Overview:
- Processor status (P) register and interrupt sampler sitting directly downstream of the 8-bit ALU.
- Consumes the ALU's registered flag outputs (CO, V, Z, N) and merges them with explicit flag commands and stack loads.
- Holds C/Z/I/D/V/N and drives carry-in and the BCD mode back upstream to the ALU.
- Qualifies IRQ against the I flag and edge-detects NMI for the sequencer.

Parameters:
- P_UNUSED_BIT, 1, constant value reported in P[5].
- I_MASK_DELAY, 1, number of RDY-qualified cycles between an I-flag change and its effect on IRQ masking (0 or 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RDY  in  1  global stall; when low, every flag/pending register holds (NMI edge capture excepted).
- alu_CO, alu_V, alu_Z, alu_N  in  1 each  registered ALU flags, valid the cycle after the ALU op.
- flag_upd  in  1  current ALU op must update flags.
- upd_mask  in  4  {N,V,Z,C} bits written by flag_upd.
- flag_cmd_en  in  1  explicit flag command strobe.
- flag_cmd  in  3  command: 0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLD, 5 SED, 6 CLV, 7 reserved (no-op).
- plp  in  1  load P from DI (PLP/RTI).
- DI  in  8  data bus in.
- set_i  in  1  interrupt entry; forces I=1.
- brk  in  1  selects B=1 in P_push.
- IRQ_n  in  1  level IRQ, active low.
- NMI_n  in  1  edge NMI, active low.
- nmi_ack, irq_ack  in  1  sequencer accepted interrupt.
- P  out  8  {N,V,P_UNUSED_BIT,0,D,I,Z,C}.
- P_push  out  8  P with bit4 = brk and bit5 = 1.
- C_out  out  1  carry to ALU CI.
- D_out  out  1  to ALU BCD.
- irq_pending, nmi_pending  out  1.

Behaviour:
- Reset (async, rst_n low):
  - C=Z=V=N=D=0, I=1.
  - Pending-update register cleared; I_delayed=1; NMI sample register=1; nmi_pending=0.
  - P=8'h24 with the default parameter.
- ALU update pipeline:
  - On a RDY edge with flag_upd=1, capture pend_valid=1 and pend_mask=upd_mask.
  - On the next RDY edge, masked bits load from alu_N/V/Z/CO and pend_valid clears, unless a new flag_upd re-arms it.
  - Latency is one RDY-qualified cycle, matching the ALU's registered outputs.
  - RDY low stalls pend_valid and pend_mask indefinitely.
- Per-bit priority in one RDY cycle, highest first:
  1. plp: N=DI[7], V=DI[6], D=DI[3], I=DI[2], Z=DI[1], C=DI[0]; DI[5:4] ignored.
  2. set_i (I only).
  3. flag_cmd.
  4. Pending ALU update.
  - Non-conflicting bits from different sources apply in the same edge.
  - plp kills any pending ALU update (pend_valid cleared).
- Outputs:
  - C_out = C and D_out = D, combinational from the register.
  - P_push[4] = brk; P[4] = 0 always.
- IRQ:
  - irq_pending = ~IRQ_n & ~I_eff, combinational.
  - I_eff = I when I_MASK_DELAY=0; otherwise I_delayed, a copy of I updated on each RDY edge.
  - Consequence: CLI followed immediately by an asserted IRQ is masked for one further RDY cycle.
  - irq_ack has no state effect beyond set_i.
- NMI:
  - NMI_n is registered every clk regardless of RDY.
  - A 1→0 transition sets nmi_pending.
  - nmi_ack with RDY clears nmi_pending.
  - A new edge in the same cycle as the ack wins, so nmi_pending stays 1.
  - Holding NMI_n low produces no further pendings.
- Reserved flag_cmd=7: no effect.
- flag_cmd_en together with plp: plp wins for every bit.
- Reset asserted mid-pipeline discards the pending update and any pending NMI.

Test Plan:
1. Reset → P=8'h24, C_out=0, D_out=0, irq_pending=0 with IRQ_n=0, nmi_pending=0.
2. flag_upd=1, upd_mask=4'b1111 at edge k; alu_N=1, V=0, Z=0, CO=1 after edge k → P=8'hA5 after edge k+1. Repeat with RDY low for 3 cycles between → P unchanged until the first RDY edge.
3. Pending update with mask 4'b0011 (Z,C) together with flag_cmd=SEC and alu_CO=0 → C=1 (command wins) and Z loaded from ALU. Same cycle with plp, DI=8'hC3 → P=8'hE3 and pending discarded.
4. I=1, IRQ_n=0, issue CLI → irq_pending stays 0 for one RDY cycle, then 1. SEI → irq_pending drops one RDY cycle later.
5. NMI_n 1→0 with RDY=0 → nmi_pending=1 and held. nmi_ack with RDY=1 → cleared. Hold NMI_n low → no re-trigger. New edge coincident with ack → nmi_pending remains 1.
6. brk=1 with P=8'h24 → P_push=8'h34. Assert rst_n=0 asynchronously mid-pending → P=8'h24 immediately, pend_valid=0.
